// File: rtl/proc_pkg.sv
// Shared processor constants for the register file and its access controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package proc_pkg;
    localparam int DW   = 16;       // data width of the register file ports
    localparam int AW   = 4;        // register address width
    localparam int NREG = 2 ** AW;  // number of architectural registers
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register marks an in-flight write; pending count and stray-writeback flag.
// Latency: set/clear become visible on busy one cycle after the request.
// Backpressure: none; set and clear are always accepted, set wins on the same index.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   set_en, set_idx     mark register set_idx busy (issued writer)
//   clr_en, clr_idx     clear register clr_idx (writeback arrived)
//   busy                per-register busy bits
//   pending_cnt         number of busy bits currently set
//   wb_err              sticky: a clear hit a register that was not busy
module regfile_scoreboard #(
    parameter int AW   = proc_pkg::AW,
    parameter int NREG = proc_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     pending_cnt,
    output logic            wb_err
);

    logic [NREG-1:0] busy_next;
    logic            cnt_inc;
    logic            cnt_dec;
    logic            stray_clr;

    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        // Applied after the clear so a same-index set keeps the bit high.
        if (set_en) begin
            busy_next[set_idx] = 1'b1;
        end
    end

    // Count only real bit transitions so pending_cnt always equals the number
    // of busy bits: a same-index set/clear leaves the bit, and the count, alone,
    // and a stray clear of an idle register does not underflow the count.
    always_comb begin
        cnt_inc   = set_en && !busy[set_idx];
        cnt_dec   = clr_en && busy[clr_idx] && !(set_en && (set_idx == clr_idx));
        stray_clr = clr_en && !busy[clr_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= '0;
            pending_cnt <= '0;
            wb_err      <= 1'b0;
        end else begin
            busy        <= busy_next;
            pending_cnt <= pending_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
            if (stray_clr) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Issue-side regfile controller: reads operands (with writeback bypass), stalls RAW/WAW, drives the write port.
// Latency: an accepted issue appears on op_* one cycle later; writebacks pass straight through to the write port.
// Backpressure: issue_ready drops on a hazard or when the full operand stage is not being consumed; writebacks never stall.
//
// Ports:
//   clk, rst                               clock, asynchronous active-low reset
//   issue_valid/ready, issue_rs1/rs2/rd/wen issue request and handshake
//   op_valid/ready, op_a/b, op_rd, op_wen  one-entry operand stage toward execute
//   wb_valid, wb_rd, wb_data               writeback bus (always accepted)
//   ra1, ra2, rd1, rd2                     regfile read ports (combinational read)
//   we, wa1, wd1                           regfile write port
//   busy, pending_cnt, wb_err              scoreboard debug/status
module regfile_access_ctrl #(
    parameter int DW = proc_pkg::DW,
    parameter int AW = proc_pkg::AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [AW-1:0]    issue_rs1,
    input  logic [AW-1:0]    issue_rs2,
    input  logic [AW-1:0]    issue_rd,
    input  logic             issue_wen,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [DW-1:0]    op_a,
    output logic [DW-1:0]    op_b,
    output logic [AW-1:0]    op_rd,
    output logic             op_wen,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic [DW-1:0]    wb_data,
    output logic [AW-1:0]    ra1,
    output logic [AW-1:0]    ra2,
    input  logic [DW-1:0]    rd1,
    input  logic [DW-1:0]    rd2,
    output logic             we,
    output logic [AW-1:0]    wa1,
    output logic [DW-1:0]    wd1,
    output logic [2**AW-1:0] busy,
    output logic [AW:0]      pending_cnt,
    output logic             wb_err
);

    localparam int NREG = 2 ** AW;

    logic          byp1;
    logic          byp2;
    logic          wb_hits_rd;
    logic          haz;
    logic          accept;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;

    // Regfile ports are pure wiring; the write lands on the same edge that
    // clears the matching busy bit.
    always_comb begin
        ra1 = issue_rs1;
        ra2 = issue_rs2;
        we  = wb_valid;
        wa1 = wb_rd;
        wd1 = wb_data;
    end

    // A writeback arriving this cycle is not yet in the regfile, so forward it.
    always_comb begin
        byp1       = wb_valid && (wb_rd == issue_rs1);
        byp2       = wb_valid && (wb_rd == issue_rs2);
        wb_hits_rd = wb_valid && (wb_rd == issue_rd);
        src_a      = byp1 ? wb_data : rd1;
        src_b      = byp2 ? wb_data : rd2;
    end

    // A busy source is fine if its writeback is being bypassed this cycle; a
    // busy destination is fine if it retires this cycle (set then wins).
    // Hazard is evaluated from the request fields only, so issue_ready never
    // depends on issue_valid.
    always_comb begin
        haz = (busy[issue_rs1] && !byp1)
           || (busy[issue_rs2] && !byp2)
           || (issue_wen && busy[issue_rd] && !wb_hits_rd);
        issue_ready = (!op_valid || op_ready) && !haz;
        accept      = issue_valid && issue_ready;
    end

    regfile_scoreboard #(
        .AW   (AW),
        .NREG (NREG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (accept && issue_wen),
        .set_idx     (issue_rd),
        .clr_en      (wb_valid),
        .clr_idx     (wb_rd),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .wb_err      (wb_err)
    );

    // One-entry operand stage. Data fields only load on accept so they hold
    // their last value after the entry is consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_rd    <= '0;
            op_wen   <= 1'b0;
        end else if (accept) begin
            op_valid <= 1'b1;
            op_a     <= src_a;
            op_b     <= src_b;
            op_rd    <= issue_rd;
            op_wen   <= issue_wen;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 16x16 regfile model.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_access_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          issue_valid;
    logic          issue_ready;
    logic [AW-1:0] issue_rs1;
    logic [AW-1:0] issue_rs2;
    logic [AW-1:0] issue_rd;
    logic          issue_wen;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [AW-1:0] op_rd;
    logic          op_wen;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          we;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [15:0]   busy;
    logic [AW:0]   pending_cnt;
    logic          wb_err;

    int checks_total;
    int checks_passed;

    regfile_access_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_wen   (issue_wen),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_rd       (op_rd),
        .op_wen      (op_wen),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ra1         (ra1),
        .ra2         (ra2),
        .rd1         (rd1),
        .rd2         (rd2),
        .we          (we),
        .wa1         (wa1),
        .wd1         (wd1),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .wb_err      (wb_err)
    );

    // Behavioural regfile: preloaded while reset is held, written from the
    // DUT write port otherwise, read combinationally.
    logic [DW-1:0] regs [16];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
            regs[1] <= 16'hAAAA;
            regs[2] <= 16'hBBBB;
        end else if (we) begin
            regs[wa1] <= wd1;
        end
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        issue_rd    = '0;
        issue_wen   = 1'b0;
        op_ready    = 1'b1;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;

        // 1. Reset with random activity on the inputs, then idle.
        rst         = 1'b0;
        issue_valid = 1'($urandom);
        issue_rd    = 4'($urandom);
        issue_wen   = 1'($urandom);
        op_ready    = 1'($urandom);
        wb_rd       = 4'($urandom);
        wb_data     = 16'($urandom);
        issue_rs1   = 4'd5;
        issue_rs2   = 4'd9;
        wb_valid    = 1'b1;
        step();
        step();
        check_val("rst_op_valid", op_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ra1", ra1, 5);
        check_val("rst_ra2", ra2, 9);
        check_val("rst_we", we, 1);
        idle_inputs();
        #2;
        rst = 1'b1;
        step();
        check_val("idle_op_valid", op_valid, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_pending", pending_cnt, 0);
        check_val("idle_wb_err", wb_err, 0);
        check_val("idle_issue_ready", issue_ready, 1);
        check_val("idle_op_a", op_a, 0);

        // 2. Plain issue: r3 <- f(r1, r2).
        issue_valid = 1'b1;
        issue_rs1   = 4'd1;
        issue_rs2   = 4'd2;
        issue_rd    = 4'd3;
        issue_wen   = 1'b1;
        #1;
        check_val("plain_ready", issue_ready, 1);
        check_val("plain_ra1", ra1, 1);
        step();
        issue_valid = 1'b0;
        check_val("plain_op_valid", op_valid, 1);
        check_val("plain_op_a", op_a, 16'hAAAA);
        check_val("plain_op_b", op_b, 16'hBBBB);
        check_val("plain_op_rd", op_rd, 3);
        check_val("plain_op_wen", op_wen, 1);
        check_val("plain_busy", busy, 16'h0008);
        check_val("plain_pending", pending_cnt, 1);

        // 3. RAW on r3 stalls until its writeback, which is then bypassed.
        issue_valid = 1'b1;
        issue_rs1   = 4'd3;
        issue_rs2   = 4'd1;
        issue_rd    = 4'd5;
        issue_wen   = 1'b0;
        #1;
        check_val("raw_stall", issue_ready, 0);
        step();
        check_val("raw_consumed", op_valid, 0);
        check_val("raw_hold_a", op_a, 16'hAAAA);
        check_val("raw_still_stall", issue_ready, 0);
        wb_valid = 1'b1;
        wb_rd    = 4'd3;
        wb_data  = 16'hCCCC;
        #1;
        check_val("raw_byp_ready", issue_ready, 1);
        check_val("raw_we", we, 1);
        check_val("raw_wa1", wa1, 3);
        check_val("raw_wd1", wd1, 16'hCCCC);
        step();
        wb_valid    = 1'b0;
        issue_valid = 1'b0;
        check_val("raw_op_valid", op_valid, 1);
        check_val("raw_op_a", op_a, 16'hCCCC);
        check_val("raw_op_b", op_b, 16'hAAAA);
        check_val("raw_busy", busy, 0);
        check_val("raw_pending", pending_cnt, 0);

        // 4. Make r4 busy, then reissue to r4 while r4 writes back.
        issue_valid = 1'b1;
        issue_rs1   = 4'd0;
        issue_rs2   = 4'd0;
        issue_rd    = 4'd4;
        issue_wen   = 1'b1;
        step();
        check_val("waw_setup_busy", busy, 16'h0010);
        check_val("waw_setup_pending", pending_cnt, 1);
        issue_rs1 = 4'd1;
        issue_rs2 = 4'd2;
        wb_valid  = 1'b1;
        wb_rd     = 4'd4;
        wb_data   = 16'hDDDD;
        #1;
        check_val("waw_ready", issue_ready, 1);
        check_val("waw_we", we, 1);
        check_val("waw_wa1", wa1, 4);
        step();
        wb_valid = 1'b0;
        check_val("waw_busy", busy, 16'h0010);
        check_val("waw_pending", pending_cnt, 1);
        check_val("waw_wb_err", wb_err, 0);
        check_val("waw_op_rd", op_rd, 4);

        // 5. Backpressure: full stage, execute not ready.
        op_ready  = 1'b0;
        issue_rs1 = 4'd2;
        issue_rs2 = 4'd1;
        issue_rd  = 4'd6;
        issue_wen = 1'b0;
        #1;
        check_val("bp_ready", issue_ready, 0);
        step();
        check_val("bp_op_valid", op_valid, 1);
        check_val("bp_hold_a", op_a, 16'hAAAA);
        check_val("bp_hold_b", op_b, 16'hBBBB);
        check_val("bp_hold_rd", op_rd, 4);
        op_ready = 1'b1;
        #1;
        check_val("bp_release_ready", issue_ready, 1);
        step();
        issue_valid = 1'b0;
        check_val("b2b_op_valid", op_valid, 1);
        check_val("b2b_op_a", op_a, 16'hBBBB);
        check_val("b2b_op_b", op_b, 16'hAAAA);
        check_val("b2b_op_rd", op_rd, 6);
        check_val("b2b_op_wen", op_wen, 0);
        wb_valid = 1'b1;
        wb_rd    = 4'd4;
        wb_data  = 16'h4444;
        step();
        wb_valid = 1'b0;
        check_val("drain_pending", pending_cnt, 0);
        check_val("drain_op_valid", op_valid, 0);

        // 6. Stray writeback, then asynchronous reset mid-cycle.
        wb_valid = 1'b1;
        wb_rd    = 4'd7;
        wb_data  = 16'h1234;
        #1;
        check_val("stray_we", we, 1);
        step();
        wb_valid = 1'b0;
        check_val("stray_wb_err", wb_err, 1);
        check_val("stray_pending", pending_cnt, 0);
        issue_valid = 1'b1;
        issue_rs1   = 4'd0;
        issue_rs2   = 4'd0;
        issue_rd    = 4'd8;
        issue_wen   = 1'b1;
        op_ready    = 1'b0;
        step();
        issue_valid = 1'b0;
        check_val("sticky_wb_err", wb_err, 1);
        check_val("pre_rst_busy", busy, 16'h0100);
        check_val("pre_rst_op_valid", op_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_wb_err", wb_err, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_pending", pending_cnt, 0);
        check_val("arst_op_valid", op_valid, 0);
        #2;
        rst = 1'b1;
        step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
